// File: rtl/crumb_pkg.sv
// Shared types and constants for the crumb array sequencer.
package crumb_pkg;

  localparam int unsigned CRUMB_N_CELLS = 64;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2,
    OP_READ = 2'd3
  } op_e;

  // State encoding kept as plain constants for legacy tools that import it.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_STEP = 3'd2;
  localparam state_t S_READ = 3'd3;
  localparam state_t S_SNAP = 3'd4;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crumb_ctrl_cnt.sv
// Loadable down-counter with a phase bit; phased mode spends two advances per count.
module crumb_ctrl_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          adv,
  input  logic          phased,
  output logic          phase,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      phase <= 1'b0;
    end else if (adv) begin
      if (phased && !phase) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/crumb_ctrl.sv
// Command sequencer for a serially chained crumb array: LOAD, STEP and non-destructive READ.
// Optional post-STEP display snapshot enabled by defining CRUMB_CTRL_DISPLAY_SNAP_EN.
module crumb_ctrl
  import crumb_pkg::*;
#(
  parameter int unsigned N_CELLS = CRUMB_N_CELLS,
  parameter int unsigned GEN_W   = 8,
  parameter int unsigned GCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [GEN_W-1:0]  cmd_gens,
  input  logic              load_valid,
  input  logic              load_bit,
  output logic              load_ready,
  output logic              rd_valid,
  output logic              rd_bit,
  output logic              rd_last,
  input  logic              rd_ready,
  input  logic              chain_out,
  output logic              crumb_en,
  output logic              crumb_run,
  output logic              crumb_display,
  output logic              chain_in,
  output logic              busy,
  output logic [GCNT_W-1:0] gen_count
);

  // Counter must hold both the chain cycle count and a full STEP generation count.
  localparam int unsigned CYC_W = $clog2(2 * N_CELLS + 2);
  localparam int unsigned CW    = umax(CYC_W, GEN_W);

  state_t            state_q, state_d;
  logic              bit_q;
  logic [GEN_W-1:0]  gens_q;
  logic [GEN_W-1:0]  gens_eff_c;
  logic              cnt_load, cnt_adv, cnt_phased, cnt_phase, cnt_zero;
  logic [CW-1:0]     cnt_val;
  logic              bit_take, gens_take, gen_add;

  assign gens_eff_c = (cmd_gens == '0) ? GEN_W'(1) : cmd_gens;

  crumb_ctrl_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .adv      (cnt_adv),
    .phased   (cnt_phased),
    .phase    (cnt_phase),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_q     <= 1'b0;
      gens_q    <= '0;
      gen_count <= '0;
    end else begin
      state_q <= state_d;
      if (bit_take)  bit_q  <= load_bit;
      if (gens_take) gens_q <= gens_eff_c;
      if (gen_add)   gen_count <= gen_count + GCNT_W'(gens_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_adv    = 1'b0;
    cnt_phased = 1'b1;
    bit_take   = 1'b0;
    gens_take  = 1'b0;
    gen_add    = 1'b0;
    crumb_en   = 1'b0;
    crumb_run  = 1'b0;
    chain_in   = 1'b0;
    load_ready = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d  = S_LOAD;
              cnt_load = 1'b1;
              cnt_val  = CW'(N_CELLS - 1);
            end
            OP_STEP: begin
              state_d   = S_STEP;
              cnt_load  = 1'b1;
              cnt_val   = CW'(gens_eff_c);
              gens_take = 1'b1;
            end
            OP_READ: begin
              state_d  = S_READ;
              cnt_load = 1'b1;
              cnt_val  = CW'(N_CELLS - 1);
            end
            default: ;
          endcase
        end
      end
      // Each bit is shifted twice so a crumb's state and out_shift both get it.
      S_LOAD: begin
        if (!cnt_phase) begin
          load_ready = 1'b1;
          if (load_valid) begin
            bit_take = 1'b1;
            chain_in = load_bit;
            crumb_en = 1'b1;
            cnt_adv  = 1'b1;
          end
        end else begin
          chain_in = bit_q;
          crumb_en = 1'b1;
          cnt_adv  = 1'b1;
          if (cnt_zero) state_d = S_IDLE;
        end
      end
      // One priming cycle plus G generation cycles.
      S_STEP: begin
        crumb_en   = 1'b1;
        crumb_run  = 1'b1;
        cnt_adv    = 1'b1;
        cnt_phased = 1'b0;
        if (cnt_zero) begin
          gen_add = 1'b1;
`ifdef CRUMB_CTRL_DISPLAY_SNAP_EN
          state_d = S_SNAP;
`else
          state_d = S_IDLE;
`endif
        end
      end
      // Full-length rotation restores the chain; only even cycles present a bit.
      S_READ: begin
        chain_in = chain_out;
        if (!cnt_phase) begin
          rd_valid = 1'b1;
          rd_last  = cnt_zero;
          if (rd_ready) begin
            crumb_en = 1'b1;
            cnt_adv  = 1'b1;
          end
        end else begin
          crumb_en = 1'b1;
          cnt_adv  = 1'b1;
          if (cnt_zero) state_d = S_IDLE;
        end
      end
      S_SNAP: begin
        crumb_en = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CRUMB_CTRL_DISPLAY_SNAP_EN
  assign crumb_display = (state_q == S_SNAP);
`else
  assign crumb_display = 1'b0;
`endif

  assign rd_bit    = chain_out;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_crumb_ctrl.sv
// Directed bench for crumb_ctrl with a 3x3 crumb-array model on the shift chain.
module tb_crumb_ctrl;
  import crumb_pkg::*;

  localparam int unsigned N = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_gens;
  logic        load_valid, load_bit, load_ready;
  logic        rd_valid, rd_bit, rd_last, rd_ready;
  logic        chain_out, crumb_en, crumb_run, crumb_display, chain_in, busy;
  logic [15:0] gen_count;

  int errors = 0;
  int checks = 0;

  crumb_ctrl #(.N_CELLS(N), .GEN_W(8), .GCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_gens(cmd_gens), .load_valid(load_valid), .load_bit(load_bit),
    .load_ready(load_ready), .rd_valid(rd_valid), .rd_bit(rd_bit), .rd_last(rd_last),
    .rd_ready(rd_ready), .chain_out(chain_out), .crumb_en(crumb_en), .crumb_run(crumb_run),
    .crumb_display(crumb_display), .chain_in(chain_in), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Array model: chain stage 2c is cell c state, 2c+1 its out_shift; bounded 3x3 Life.
  logic [2*N-1:0] arr = '0;
  logic           primed = 1'b0;
  assign chain_out = arr[2*N-1];

  function automatic logic [N-1:0] life(input logic [N-1:0] s);
    logic [N-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 3 && c + dc >= 0 && c + dc < 3)
              cnt += int'(s[(r + dr) * 3 + c + dc]);
        n[r*3+c] = (cnt == 3) || (s[r*3+c] && cnt == 2);
      end
    return n;
  endfunction

  function automatic logic [2*N-1:0] step_arr(input logic [2*N-1:0] a);
    logic [N-1:0]   s;
    logic [2*N-1:0] o;
    for (int c = 0; c < N; c++) s[c] = a[2*c];
    s = life(s);
    for (int c = 0; c < N; c++) begin
      o[2*c]   = s[c];
      o[2*c+1] = s[c];
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (crumb_en && !crumb_run && !crumb_display) begin
      arr    <= {arr[2*N-2:0], chain_in};
      primed <= 1'b0;
    end else if (crumb_en && crumb_run) begin
      if (primed) arr <= step_arr(arr);
      primed <= 1'b1;
    end else begin
      primed <= 1'b0;
    end
  end

  // Mid-cycle monitors.
  int en_cnt = 0, run_cnt = 0, disp_cnt = 0, ld_p1_bad = 0;
  int cyc = 0, last_run_cyc = 0, disp_cyc = 0;
  logic hs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (crumb_en) en_cnt <= en_cnt + 1;
    if (crumb_run) begin
      run_cnt      <= run_cnt + 1;
      last_run_cyc <= cyc;
    end
    if (crumb_display) begin
      disp_cnt <= disp_cnt + 1;
      disp_cyc <= cyc;
    end
    if (hs_prev && load_ready) ld_p1_bad <= ld_p1_bad + 1;
    hs_prev <= load_valid && load_ready;
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] gens);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_gens  = gens;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_pat(input logic [N-1:0] pat, input bit gapped);
    int n;
    int gap_en;
    gap_en = 0;
    send_cmd(OP_LOAD, 8'd0);
    for (int k = 0; k < N; k++) begin
      if (gapped && (k % 2 == 1)) begin
        load_valid = 1'b0;
        #1 gap_en += int'(crumb_en);
        @(posedge clk); #1;
      end
      load_valid = 1'b1;
      load_bit   = pat[N-1-k];
      n = 0;
      while (!load_ready && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      check("load_hs_wait", 32'(n), 32'd0);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (gapped) check("load_gap_en", 32'(gap_en), 32'd0);
  endtask

  task automatic read_pat(input logic [3:0] rdy_pat, output logic [N-1:0] got,
                          output int last_bad, output int stall_bad, output int nacc,
                          output int nstall);
    int t;
    send_cmd(OP_READ, 8'd0);
    got = '0; last_bad = 0; stall_bad = 0; nacc = 0; nstall = 0; t = 0;
    while (t < 200) begin
      rd_ready = rdy_pat[t % 4];
      #1;
      if (!busy) break;
      if (rd_valid && rd_ready) begin
        if (nacc < int'(N)) got[N-1-nacc] = rd_bit;
        if (rd_last != (nacc == int'(N) - 1)) last_bad++;
        nacc++;
      end else if (rd_valid) begin
        nstall++;
        if (crumb_en) stall_bad++;
      end
      if (!rd_valid && rd_last) last_bad++;
      @(posedge clk); #1;
      t++;
    end
    rd_ready = 1'b0;
    check("read_bounded", 32'(t < 200), 32'd1);
  endtask

  task automatic run_step(input logic [7:0] gens, output int runs, output int rdy_bad);
    int t, r0;
    r0 = run_cnt;
    rdy_bad = 0;
    send_cmd(OP_STEP, gens);
    t = 0;
    while (busy && t < 600) begin
      if (cmd_ready) rdy_bad++;
      @(posedge clk); #1;
      t++;
    end
    check("step_bounded", 32'(t < 600), 32'd1);
    @(negedge clk); @(posedge clk); #1;
    runs = run_cnt - r0;
  endtask

  task automatic check_disp(input string tag, input int d0);
`ifdef CRUMB_CTRL_DISPLAY_SNAP_EN
    check({tag, "_disp_pulses"}, 32'(disp_cnt - d0), 32'd1);
    check({tag, "_disp_after_run"}, 32'(disp_cyc), 32'(last_run_cyc + 1));
`else
    check({tag, "_disp_pulses"}, 32'(disp_cnt - d0), 32'd0);
`endif
  endtask

  localparam logic [N-1:0] PAT_A  = 9'b101100101;
  localparam logic [N-1:0] BLINK_H = 9'b000111000;
  localparam logic [N-1:0] BLINK_V = 9'b010010010;

  initial begin
    logic [N-1:0] got;
    int last_bad, stall_bad, nacc, nstall, e0, runs, rdy_bad, d0, t, r0;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_gens = 8'd0;
    load_valid = 1'b0; load_bit = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_crumb_en", 32'(crumb_en), 32'd0);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_cmd(OP_NOP, 8'd0);
    check("nop_stays_idle", 32'(busy), 32'd0);

    // Gapped load, then back-to-back reads.
    e0 = en_cnt;
    load_pat(PAT_A, 1'b1);
    @(negedge clk); @(posedge clk); #1;
    check("load_en_cycles", 32'(en_cnt - e0), 32'(2 * N));
    check("load_ready_phase1", 32'(ld_p1_bad), 32'd0);
    check("load_back_idle", 32'(busy), 32'd0);

    read_pat(4'b1111, got, last_bad, stall_bad, nacc, nstall);
    check("read1_data", 32'(got), 32'(PAT_A));
    check("read1_count", 32'(nacc), 32'(N));
    check("read1_last", 32'(last_bad), 32'd0);

    e0 = en_cnt;
    read_pat(4'b1111, got, last_bad, stall_bad, nacc, nstall);
    @(negedge clk); @(posedge clk); #1;
    check("read2_data", 32'(got), 32'(PAT_A));
    check("read2_en_cycles", 32'(en_cnt - e0), 32'(2 * N));

    // Stalled read with ready pattern 1,0,0,1.
    e0 = en_cnt;
    read_pat(4'b1001, got, last_bad, stall_bad, nacc, nstall);
    @(negedge clk); @(posedge clk); #1;
    check("read3_data", 32'(got), 32'(PAT_A));
    check("read3_count", 32'(nacc), 32'(N));
    check("read3_stalls_seen", 32'(nstall > 0), 32'd1);
    check("read3_stall_en", 32'(stall_bad), 32'd0);
    check("read3_last", 32'(last_bad), 32'd0);
    check("read3_en_cycles", 32'(en_cnt - e0), 32'(2 * N));

    // Blinker evolution.
    load_pat(BLINK_H, 1'b0);
    d0 = disp_cnt;
    run_step(8'd1, runs, rdy_bad);
    check("step1_runs", 32'(runs), 32'd2);
    check("step1_cmd_ready", 32'(rdy_bad), 32'd0);
    check("step1_gen_count", 32'(gen_count), 32'd1);
    check_disp("step1", d0);
    read_pat(4'b1111, got, last_bad, stall_bad, nacc, nstall);
    check("step1_vertical", 32'(got), 32'(BLINK_V));

    d0 = disp_cnt;
    run_step(8'd0, runs, rdy_bad);
    check("step0_runs", 32'(runs), 32'd2);
    check("step0_gen_count", 32'(gen_count), 32'd2);
    check_disp("step0", d0);
    read_pat(4'b1111, got, last_bad, stall_bad, nacc, nstall);
    check("step0_horizontal", 32'(got), 32'(BLINK_H));

    run_step(8'd3, runs, rdy_bad);
    check("step3_runs", 32'(runs), 32'd4);
    check("step3_gen_count", 32'(gen_count), 32'd5);
    read_pat(4'b1111, got, last_bad, stall_bad, nacc, nstall);
    check("step3_vertical", 32'(got), 32'(BLINK_V));

    // Asynchronous reset during run cycle 3 of 9.
    r0 = run_cnt;
    send_cmd(OP_STEP, 8'd8);
    t = 0;
    while ((run_cnt - r0) < 3 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check("midstep_reached", 32'(run_cnt - r0), 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_crumb_en", 32'(crumb_en), 32'd0);
    check("arst_crumb_run", 32'(crumb_run), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_gen_count", 32'(gen_count), 32'd0);
    check("arst_misc", {28'd0, crumb_display, chain_in, rd_valid, load_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crumb_ctrl.md
Name: crumb_ctrl

Overview:
- Command-driven sequencer for a serially chained array of N_CELLS Game-of-Life crumbs.
- Owns every array control line: crumb_en, crumb_run, crumb_display and the head of the config shift chain.
- Provides three services: serial load of a pattern, stepping the array a requested number of generations, and non-destructive serial read-back by recirculating the chain.
- Sits between the tile's host/IO logic and the crumb array.

Parameters:
- N_CELLS, 64, number of crumbs in the chain. The shift chain is 2*N_CELLS stages: crumb state plus out_shift per cell.
- GEN_W, 8, width of the generation-count field of a STEP command.
- GCNT_W, 16, width of the gen_count status counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=NOP, 1=LOAD, 2=STEP, 3=READ
- cmd_gens  in  GEN_W  generations for STEP; 0 is treated as 1
- load_valid  in  1  load bit offered
- load_bit  in  1  load data
- load_ready  out  1  load bit accepted when valid&ready
- rd_valid  out  1  read bit present
- rd_bit  out  1  read data
- rd_last  out  1  final read bit
- rd_ready  in  1  sink ready; low stalls READ
- chain_out  in  1  out_shift of the last crumb
- crumb_en  out  1  array enable
- crumb_run  out  1  array run
- crumb_display  out  1  array display pulse
- chain_in  out  1  in_shift of the first crumb
- busy  out  1  high when not IDLE
- gen_count  out  GCNT_W  generations executed since reset; wraps

Behaviour:
- Reset values: state=IDLE; crumb_en, crumb_run, crumb_display, chain_in, rd_valid, rd_last, load_ready and busy = 0; cmd_ready=1; gen_count=0; all counters 0.
- Reset mid-operation aborts immediately, with no cleanup. Array contents are then undefined (the array resets synchronously).
- IDLE:
  - crumb_en=0.
  - cmd_valid&cmd_ready with op LOAD/STEP/READ moves to the matching state on the next cycle.
  - NOP is accepted and stays in IDLE.
  - Stream index k always maps to cell N_CELLS-1-k.
- LOAD: N_CELLS bits, each occupying 2 shift cycles (phase 0/1).
  - Phase 0: load_ready=1. On handshake, latch the bit, drive chain_in=bit, crumb_en=1, crumb_run=0, and go to phase 1.
  - Phase 0 with no handshake: crumb_en=0, array frozen.
  - Phase 1: load_ready=0, chain_in=latched bit, crumb_en=1.
  - After the phase-1 cycle of bit N_CELLS-1, return to IDLE.
  - Result: every crumb state equals its out_shift.
- STEP:
  - crumb_en=1 and crumb_run=1 for exactly G+1 consecutive cycles, where G=max(cmd_gens,1). The first cycle primes the array's registered neighbour count.
  - gen_count increments by G on exit.
  - Not interruptible; cmd_ready=0 throughout.
- READ: 2*N_CELLS rotate cycles.
  - Each rotate cycle drives crumb_en=1, crumb_run=0, chain_in=chain_out.
  - rd_bit=chain_out. rd_valid=1 on even rotate cycles only (combinational from state/phase).
  - Even cycle with rd_ready=0: crumb_en=0, no rotation, rd_valid stays asserted.
  - Odd cycles are never stalled.
  - rd_last accompanies bit N_CELLS-1.
  - Array contents after READ are identical to those before.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored; the command is held by the requester.
  - load_valid outside LOAD and rd_ready outside READ are ignored.
- crumb_display=0 except as given under Optional Feature.
- Counter arithmetic is unsigned. The cycle counter is clog2(2*N_CELLS+2) bits.

Optional Feature:
- Macro: CRUMB_CTRL_DISPLAY_SNAP_EN.
  - Defined: after each STEP, one extra SNAP cycle with crumb_en=1, crumb_run=0, crumb_display=1, which copies state into the display chain. busy stays high during SNAP, then the block returns to IDLE.
  - Undefined: no SNAP state; crumb_display is tied 0.

Decomposition:
- Package crumb_pkg holds:
  - the op enum: OP_NOP, OP_LOAD, OP_STEP, OP_READ;
  - the state enum: S_IDLE, S_LOAD, S_STEP, S_READ, S_SNAP;
  - default N_CELLS.
- One natural sub-module, crumb_ctrl_cnt: the loadable down-counter with phase bit, shared by LOAD, STEP and READ.
- The FSM stays in crumb_ctrl.

Test Plan:
- Reset asserted mid-STEP (cycle 3 of 9) -> all outputs return to reset values asynchronously; gen_count=0; cmd_ready=1.
- N_CELLS=8, LOAD 8'b10110010 with load_valid gapped every other bit -> exactly 16 en cycles; load_ready never high in phase 1.
- LOAD pattern then READ with rd_ready=1 -> rd stream equals load stream, rd_last on 8th bit. A second READ returns the same stream (non-destructive).
- READ with rd_ready toggling 1,0,0,1 -> no bit lost or duplicated; crumb_en low on stalled cycles.
- Blinker loaded (3 live cells in row of 3x3 model), STEP gens=1 -> crumb_run high exactly 2 cycles; READ shows vertical blinker; gen_count=1.
- STEP gens=0 -> behaves as 1 (2 run cycles). With CRUMB_CTRL_DISPLAY_SNAP_EN, crumb_display pulses once, one cycle after run falls.
